// File: rtl/logic_gate_bist_pkg.sv
// Shared constants for the logic_gate self-test engine: vector/counter widths and FSM encoding.
package logic_gate_bist_pkg;

  localparam int unsigned NUM_VEC = 8;
  localparam int unsigned VEC_W   = 3;
  localparam int unsigned CNT_W   = 4;

  typedef logic [1:0] state_t;

  localparam state_t StIdle   = 2'd0;
  localparam state_t StDrive  = 2'd1;
  localparam state_t StSample = 2'd2;
  localparam state_t StDone   = 2'd3;

endpackage

// File: rtl/bist_settle_timer.sv
// Settle timer: loadable down-counter that stops at zero and flags it.
module bist_settle_timer
  import logic_gate_bist_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             dec_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Load has priority; decrement saturates at zero so the count never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Counter register, cleared by asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/logic_gate_bist.sv
// Self-test engine for the 3-input logic_gate: steps all eight input vectors, samples the response
// after a settle interval and compares the captured truth table against EXPECTED.
// Optional build macro LOGIC_GATE_BIST_STOP_ON_FAIL_EN ends a run at the first mismatching vector.
module logic_gate_bist
  import logic_gate_bist_pkg::*;
#(
  parameter logic [NUM_VEC-1:0] EXPECTED      = 8'hE8,
  parameter int unsigned        SETTLE_CYCLES = 2
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  output logic               o_A,
  output logic               o_B,
  output logic               o_C,
  input  logic               i_F,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_pass,
  output logic [NUM_VEC-1:0] o_captured,
  output logic [NUM_VEC-1:0] o_mismatch
);

  if ((SETTLE_CYCLES == 0) || (SETTLE_CYCLES > 15)) begin : g_bad_settle
    $error("SETTLE_CYCLES must be within 1..15");
  end

  localparam logic [CNT_W-1:0] SettleLoad = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [VEC_W-1:0] LastVec    = VEC_W'(NUM_VEC - 1);

  state_t             state_q, state_d;
  logic [VEC_W-1:0]   vec_q, vec_d;
  logic [NUM_VEC-1:0] cap_q, cap_d;
  logic [NUM_VEC-1:0] mism_q, mism_d;
  logic               pass_q, pass_d;
  logic               timer_load, timer_dec, timer_zero;
  logic               bit_fail;

  bist_settle_timer u_timer (
    .clk_i      (i_clk),
    .rst_i      (i_rst),
    .load_i     (timer_load),
    .dec_i      (timer_dec),
    .load_val_i (SettleLoad),
    .zero_o     (timer_zero)
  );

  // Sequencing FSM: vector stepping, capture and pass evaluation.
  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    cap_d      = cap_q;
    mism_d     = mism_q;
    pass_d     = pass_q;
    timer_load = 1'b0;
    timer_dec  = 1'b0;
    bit_fail   = 1'b0;
    case (state_q)
      StIdle: begin
        if (i_start) begin
          cap_d      = '0;
          mism_d     = '0;
          pass_d     = 1'b0;
          vec_d      = '0;
          timer_load = 1'b1;
          state_d    = StDrive;
        end
      end
      StDrive: begin
        timer_dec = 1'b1;
        if (timer_zero) begin
          state_d = StSample;
        end
      end
      StSample: begin
        bit_fail       = i_F ^ EXPECTED[vec_q];
        cap_d[vec_q]   = i_F;
        mism_d[vec_q]  = bit_fail;
        if (vec_q == LastVec) begin
          // Pass is resolved on entry to DONE so it is valid during the done pulse.
          pass_d  = (cap_d == EXPECTED);
          state_d = StDone;
        end
`ifdef LOGIC_GATE_BIST_STOP_ON_FAIL_EN
        else if (bit_fail) begin
          pass_d  = 1'b0;
          state_d = StDone;
        end
`endif
        else begin
          vec_d      = vec_q + VEC_W'(1);
          timer_load = 1'b1;
          state_d    = StDrive;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and result registers; reset aborts any run without a done pulse.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= StIdle;
      vec_q   <= '0;
      cap_q   <= '0;
      mism_q  <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cap_q   <= cap_d;
      mism_q  <= mism_d;
      pass_q  <= pass_d;
    end
  end

  // Drive outputs follow the vector register, so the last vector persists after a run.
  assign o_A        = vec_q[2];
  assign o_B        = vec_q[1];
  assign o_C        = vec_q[0];
  assign o_busy     = (state_q == StDrive) || (state_q == StSample);
  assign o_done     = (state_q == StDone);
  assign o_pass     = pass_q;
  assign o_captured = cap_q;
  assign o_mismatch = mism_q;

endmodule

// File: tb/tb_logic_gate_bist.sv
// Self-checking bench for logic_gate_bist with a behavioural majority gate as the device under test.
module tb_logic_gate_bist;

  logic       clk = 1'b0;
  logic       rst, start, start1;
  logic       a, b, c, f, busy, done, pass;
  logic [7:0] cap, mism;
  logic       a1, b1, c1, f1, busy1, done1, pass1;
  logic [7:0] cap1, mism1;
  bit         fault;
  int         n_cmp = 0;
  int         n_bad = 0;

  typedef struct packed {
    logic [7:0] cap;
    logic [7:0] mism;
    logic       pass;
  } res_t;

  logic [2:0] exp_vec[$];
  res_t       exp_res[$];

  always #5 clk = ~clk;

  // Majority gate, optionally stuck high on vector 2.
  function automatic logic gate_model(input logic [2:0] v, input bit flt);
    gate_model = (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]) | (flt && (v == 3'd2));
  endfunction

  assign f  = gate_model({a, b, c}, fault);
  assign f1 = gate_model({a1, b1, c1}, 1'b0);

  logic_gate_bist #(.EXPECTED(8'hE8), .SETTLE_CYCLES(2)) u_dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .o_A        (a),
    .o_B        (b),
    .o_C        (c),
    .i_F        (f),
    .o_busy     (busy),
    .o_done     (done),
    .o_pass     (pass),
    .o_captured (cap),
    .o_mismatch (mism)
  );

  logic_gate_bist #(.EXPECTED(8'hE8), .SETTLE_CYCLES(1)) u_dut1 (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start1),
    .o_A        (a1),
    .o_B        (b1),
    .o_C        (c1),
    .i_F        (f1),
    .o_busy     (busy1),
    .o_done     (done1),
    .o_pass     (pass1),
    .o_captured (cap1),
    .o_mismatch (mism1)
  );

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({a, b, c, busy, done, pass} !== 6'b0 || cap !== 8'h00 || mism !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_dut: got abc=%b busy=%b done=%b pass=%b cap=%h mism=%h, want all 0",
               {a, b, c}, busy, done, pass, cap, mism);
    end
    n_cmp++;
    if ({a1, b1, c1, busy1, done1, pass1} !== 6'b0 || cap1 !== 8'h00 || mism1 !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_dut1: got abc=%b busy=%b done=%b pass=%b cap=%h mism=%h, want all 0",
               {a1, b1, c1}, busy1, done1, pass1, cap1, mism1);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || {a, b, c} !== 3'd0) begin
      n_bad++;
      $display("FAIL reset_idle: got busy=%b done=%b abc=%b, want 0 0 000", busy, done, {a, b, c});
    end
  endtask

  task automatic test_full_run(input bit flt, input logic [7:0] ecap, input logic [7:0] emism,
                               input logic epass);
    res_t       er;
    logic [2:0] ev;
    fault = flt;
    for (int v = 0; v < 8; v++) repeat (3) exp_vec.push_back(v[2:0]);
    exp_res.push_back('{cap: ecap, mism: emism, pass: epass});
    @(negedge clk);
    start = 1'b1;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      start = 1'b0;
      ev = exp_vec.pop_front();
      n_cmp++;
      if ({a, b, c} !== ev || busy !== 1'b1 || done !== 1'b0) begin
        n_bad++;
        $display("FAIL run_vec[%0d]: got abc=%b busy=%b done=%b, want abc=%b busy=1 done=0",
                 k, {a, b, c}, busy, done, ev);
      end
      if (k == 0) begin
        n_cmp++;
        if (cap !== 8'h00 || mism !== 8'h00 || pass !== 1'b0) begin
          n_bad++;
          $display("FAIL run_clear: got cap=%h mism=%h pass=%b, want 00 00 0", cap, mism, pass);
        end
      end
    end
    @(negedge clk);
    er = exp_res.pop_front();
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0 || cap !== er.cap || mism !== er.mism || pass !== er.pass)
    begin
      n_bad++;
      $display("FAIL run_done: got done=%b busy=%b cap=%h mism=%h pass=%b, want 1 0 %h %h %b",
               done, busy, cap, mism, pass, er.cap, er.mism, er.pass);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0 || {a, b, c} !== 3'd7 || cap !== er.cap ||
        mism !== er.mism || pass !== er.pass) begin
      n_bad++;
      $display("FAIL run_hold: got done=%b busy=%b abc=%b cap=%h mism=%h pass=%b, want 0 0 111 %h %h %b",
               done, busy, {a, b, c}, cap, mism, pass, er.cap, er.mism, er.pass);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [2:0] ev;
    fault = 1'b1;
    for (int k = 0; k < 11; k++) exp_vec.push_back(3'(k / 3));
    @(negedge clk);
    start = 1'b1;
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      start = 1'b0;
      ev = exp_vec.pop_front();
      n_cmp++;
      if ({a, b, c} !== ev || busy !== 1'b1) begin
        n_bad++;
        $display("FAIL abort_vec[%0d]: got abc=%b busy=%b, want abc=%b busy=1", k, {a, b, c}, busy, ev);
      end
    end
    n_cmp++;
    if (cap !== 8'h04 || mism !== 8'h04) begin
      n_bad++;
      $display("FAIL abort_partial: got cap=%h mism=%h, want 04 04", cap, mism);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if ({a, b, c, busy, done, pass} !== 6'b0 || cap !== 8'h00 || mism !== 8'h00) begin
      n_bad++;
      $display("FAIL abort_reset: got abc=%b busy=%b done=%b pass=%b cap=%h mism=%h, want all 0",
               {a, b, c}, busy, done, pass, cap, mism);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_bad++;
        $display("FAIL abort_no_done[%0d]: got done=%b busy=%b, want 0 0", k, done, busy);
      end
    end
    test_full_run(1'b0, 8'hE8, 8'h00, 1'b1);
  endtask

  task automatic test_back_to_back();
    res_t       er;
    logic [2:0] ev;
    fault = 1'b0;
    for (int r = 0; r < 2; r++) begin
      for (int v = 0; v < 8; v++) repeat (3) exp_vec.push_back(v[2:0]);
      exp_res.push_back('{cap: 8'hE8, mism: 8'h00, pass: 1'b1});
    end
    @(negedge clk);
    start = 1'b1;
    for (int k = 0; k < 53; k++) begin
      @(negedge clk);
      if (k == 50) start = 1'b0;
      n_cmp++;
      if (k == 24 || k == 50) begin
        er = exp_res.pop_front();
        if (done !== 1'b1 || cap !== er.cap || mism !== er.mism || pass !== er.pass) begin
          n_bad++;
          $display("FAIL b2b_done[%0d]: got done=%b cap=%h mism=%h pass=%b, want 1 %h %h %b",
                   k, done, cap, mism, pass, er.cap, er.mism, er.pass);
        end
      end else if (k == 25 || k > 50) begin
        if (done !== 1'b0 || busy !== 1'b0 || {a, b, c} !== 3'd7) begin
          n_bad++;
          $display("FAIL b2b_idle[%0d]: got done=%b busy=%b abc=%b, want 0 0 111",
                   k, done, busy, {a, b, c});
        end
      end else begin
        ev = exp_vec.pop_front();
        if ({a, b, c} !== ev || busy !== 1'b1 || done !== 1'b0) begin
          n_bad++;
          $display("FAIL b2b_vec[%0d]: got abc=%b busy=%b done=%b, want abc=%b busy=1 done=0",
                   k, {a, b, c}, busy, done, ev);
        end
      end
    end
  endtask

  task automatic test_settle1();
    logic [2:0] ev;
    for (int v = 0; v < 8; v++) repeat (2) exp_vec.push_back(v[2:0]);
    @(negedge clk);
    start1 = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      start1 = 1'b0;
      ev = exp_vec.pop_front();
      n_cmp++;
      if ({a1, b1, c1} !== ev || busy1 !== 1'b1 || done1 !== 1'b0) begin
        n_bad++;
        $display("FAIL s1_vec[%0d]: got abc=%b busy=%b done=%b, want abc=%b busy=1 done=0",
                 k, {a1, b1, c1}, busy1, done1, ev);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (done1 !== 1'b1 || cap1 !== 8'hE8 || mism1 !== 8'h00 || pass1 !== 1'b1) begin
      n_bad++;
      $display("FAIL s1_done: got done=%b cap=%h mism=%h pass=%b, want 1 e8 00 1",
               done1, cap1, mism1, pass1);
    end
    @(negedge clk);
    n_cmp++;
    if (done1 !== 1'b0 || busy1 !== 1'b0) begin
      n_bad++;
      $display("FAIL s1_idle: got done=%b busy=%b, want 0 0", done1, busy1);
    end
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    start1 = 1'b0;
    fault  = 1'b0;
    test_reset();
    test_full_run(1'b0, 8'hE8, 8'h00, 1'b1);
    test_full_run(1'b1, 8'hEC, 8'h04, 1'b0);
    test_reset_mid_run();
    test_back_to_back();
    test_settle1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
